start_done_initiator: RTL
=========================

# start_done_initiator

Issues a programmed batch of one-cycle `start` pulses to a start/done worker FSM. After each pulse it waits for the worker's `done` before issuing the next. It is the initiating end of the team's start/done handshake. It sits between a control register/sequencer and any worker FSM, and adds per-job timeout, bounded retry and batch completion reporting.

## Interface
Parameters:
- `CNT_W`, 8, width of the job count and progress counters
- `TIMEOUT_CYCLES`, 16, WAIT cycles without `done` before a timeout fires (≥2)
- `MAX_RETRY`, 2, re-issues allowed per job after a timeout (0 = none)

Ports:
- `clk`  input  1  single clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `req_valid`  input  1  batch request
- `req_count`  input  CNT_W  number of jobs in the batch, sampled on accept
- `req_ready`  output  1  high only in IDLE
- `start`  output  1  one-cycle pulse to the worker
- `done`  input  1  worker completion, sampled only in WAIT
- `busy`  output  1  high in every state except IDLE
- `jobs_done`  output  CNT_W  number of completed jobs in the current or last batch
- `batch_done`  output  1  one-cycle pulse when the batch completes
- `timeout_err`  output  1  one-cycle pulse when retries are exhausted

## Operation
- State encodings: IDLE, ISSUE, WAIT, GAP, FINISH, ERROR.
- **Reset:** async assert → IDLE. `start`, `busy`, `batch_done` and `timeout_err` are 0; `jobs_done`, the remaining count, the timer and the retry count are 0; `req_ready` is 1.
- **IDLE:**
  - The request is accepted when `req_valid && req_ready`.
  - On accept: latch remaining = `req_count`, clear `jobs_done` and the retry count.
  - Next state: FINISH if `req_count`==0, else ISSUE.
- **ISSUE:** `start`=1 for exactly this cycle; clear the timer; → WAIT.
- **WAIT:**
  - `done`=1: `jobs_done`+1, remaining−1, clear the retry count. Go to FINISH if remaining was 1, else GAP.
  - `done`=0 and timer==`TIMEOUT_CYCLES`−1: go to ISSUE with retry+1 if retry<`MAX_RETRY`, else go to ERROR.
  - Otherwise: timer+1.
- **GAP:** one idle cycle so the worker returns to idle → ISSUE.
- **FINISH:** `batch_done`=1 → IDLE.
- **ERROR:** `timeout_err`=1 → IDLE. `jobs_done` keeps the partial count.
- Arithmetic: counters are unsigned CNT_W bits and never wrap; remaining is never decremented below 0. The timer width is clog2(`TIMEOUT_CYCLES`); the retry counter width is clog2(`MAX_RETRY`+1), minimum 1.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Accept at edge k → `start` is high in cycle k+1 → WAIT begins at k+2.
- Per-job cost when the worker answers in its first WAIT cycle: ISSUE + WAIT + GAP = 3 cycles. The last job replaces GAP with FINISH.
- A job with no `done` times out after exactly `TIMEOUT_CYCLES` WAIT cycles; the next ISSUE follows on the next cycle.
- Boundary cases:
  - `done` and timeout in the same cycle: `done` wins.
  - `done` outside WAIT (IDLE, ISSUE, GAP, FINISH, ERROR) is ignored with no counter change.
  - `req_valid` while busy is not accepted; a request held through FINISH/ERROR is accepted in the following IDLE cycle.
  - `rst_n` low mid-batch: immediate return to reset values; any in-flight `start` pulse is truncated.
- `batch_done` and `timeout_err` are never high together and are never high in consecutive cycles of the same batch.

## Structure
- Shared package `start_done_pkg`:
  - state enum `sd_state_t` (IDLE, ISSUE, WAIT, GAP, FINISH, ERROR);
  - default constants `SD_CNT_W`=8, `SD_TIMEOUT`=16, `SD_MAX_RETRY`=2.
  - The worker FSM reuses the same package.
- One natural sub-module, `sd_timeout_timer`: load/clear, enable, and an `expired` flag at `TIMEOUT_CYCLES`−1. Everything else stays in the top module.

## Test plan
- Reset and single job: hold `rst_n`=0, check all reset values. Release, then `req_count`=1 with the worker answering `done` 2 cycles after `start` → exactly one `start` pulse, `jobs_done`=1, `batch_done` pulse 1 cycle after `done`, then IDLE with `req_ready`=1.
- Batch of 3 with `done` in the first WAIT cycle → 3 `start` pulses spaced 3 cycles apart, `jobs_done`=3, one `batch_done`.
- Zero-count request: `req_count`=0 → no `start`, `batch_done` in cycle k+1, `jobs_done`=0.
- Timeout and retry: worker silent for the first issue, answers on the second → 2 `start` pulses 17 cycles apart (`TIMEOUT_CYCLES`=16), no `timeout_err`, `jobs_done`=1.
- Retry exhaustion: worker never answers with `MAX_RETRY`=2 → 3 `start` pulses, then `timeout_err` pulse, `jobs_done`=0, no `batch_done`.
- Corner events:
  - `done` coincident with the timeout edge → counted as done, no retry.
  - Spurious `done` in GAP → ignored.
  - `rst_n` dropped while in WAIT of job 2 of 4 → outputs return to reset values asynchronously; the next batch starts cleanly.

Source files
------------

// File: rtl/start_done_pkg.sv
// Shared types and defaults for the start/done handshake (initiator and worker).
package start_done_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4,
    ERROR  = 3'd5
  } sd_state_t;

  localparam int SD_CNT_W     = 8;
  localparam int SD_TIMEOUT   = 16;
  localparam int SD_MAX_RETRY = 2;

endpackage

// File: rtl/sd_timeout_timer.sv
// Per-job WAIT timer: cleared on issue, counts enabled cycles, flags the last allowed cycle.
module sd_timeout_timer
  import start_done_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SD_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cnt_q;

  assign expired_o = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Holds at the expiry value so the count can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (clr_i)               cnt_q <= '0;
    else if (en_i && !expired_o)  cnt_q <= cnt_q + TW'(1);
  end

endmodule

// File: rtl/start_done_initiator.sv
// Issues a batch of start pulses, one per job, waiting for done with timeout and bounded retry.
module start_done_initiator
  import start_done_pkg::*;
#(
  parameter int CNT_W          = SD_CNT_W,
  parameter int TIMEOUT_CYCLES = SD_TIMEOUT,
  parameter int MAX_RETRY      = SD_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic             batch_done,
  output logic             timeout_err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sd_state_t        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             tmr_clr, tmr_en, tmr_exp;

  sd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    jobs_d  = jobs_q;
    retry_d = retry_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rem_d   = req_count;
          jobs_d  = '0;
          retry_d = '0;
          state_d = (req_count == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        tmr_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over a timeout landing in the same cycle
        if (done) begin
          jobs_d  = (jobs_q != '1) ? jobs_q + CNT_W'(1) : jobs_q;
          rem_d   = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
          retry_d = '0;
          state_d = (rem_q <= CNT_W'(1)) ? FINISH : GAP;
        end else if (tmr_exp) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ISSUE;
          end else begin
            state_d = ERROR;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP:     state_d = ISSUE;
      FINISH:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      jobs_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      jobs_q  <= jobs_d;
      retry_q <= retry_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign start       = (state_q == ISSUE);
  assign batch_done  = (state_q == FINISH);
  assign timeout_err = (state_q == ERROR);
  assign jobs_done   = jobs_q;

endmodule
